// File: rtl/bus_pkg.sv
// Shared definitions for the two-requester register-bus arbiter:
// bus width, FSM state encoding, requester identifiers and the return-match test.
package bus_pkg;

  localparam int BUS_W = 16;

  typedef logic [BUS_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // A returning beat answers the outstanding transaction only if address and direction agree.
  function automatic logic bus_match(input logic  beat_valid,
                                     input word_t beat_addr,
                                     input logic  beat_rw,
                                     input word_t want_addr,
                                     input logic  want_rw);
    return beat_valid && (beat_addr == want_addr) && (beat_rw == want_rw);
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not served last.
module rr_grant2
  import bus_pkg::*;
(
  input  logic    valid_a,
  input  logic    valid_b,
  input  req_id_t last_served,
  output logic    grant_a,
  output logic    grant_b
);

  assign grant_a = valid_a && (!valid_b || (last_served == REQ_B));
  assign grant_b = valid_b && (!valid_a || (last_served == REQ_A));

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates requesters a and b onto a single register-bus chain, keeping one
// transaction in flight and abandoning it after TIMEOUT unanswered WAIT cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_addr_i,
  input  logic [15:0] a_wdata_i,
  input  logic        a_rw_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  output logic [15:0] a_rdata_o,
  output logic        a_resp_o,
  input  logic [15:0] b_addr_i,
  input  logic [15:0] b_wdata_i,
  input  logic        b_rw_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  output logic [15:0] b_rdata_o,
  output logic        b_resp_o,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o,
  output logic        rw_o,
  output logic        valid_o,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        timeout_o
);

  // Counter value on the last WAIT cycle before the transaction is abandoned.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t  state_reg, state_next;
  req_id_t owner_reg, last_reg;
  word_t   addr_reg, wdata_reg;
  logic    rw_reg;
  logic [15:0] cnt_reg;
  word_t   a_rdata_reg, b_rdata_reg;
  logic    timed_out_reg;

  logic grant_a, grant_b;
  logic accept, match, expire;
  logic unused_ok;

  rr_grant2 u_grant (
    .valid_a     (a_valid_i),
    .valid_b     (b_valid_i),
    .last_served (last_reg),
    .grant_a     (grant_a),
    .grant_b     (grant_b)
  );

  // Grants are offered only while idle and out of reset.
  assign a_ready_o = !rst && (state_reg == ST_IDLE) && grant_a;
  assign b_ready_o = !rst && (state_reg == ST_IDLE) && grant_b;
  assign accept    = a_ready_o || b_ready_o;

  assign match  = (state_reg == ST_WAIT) && bus_match(valid_i, addr_i, rw_i, addr_reg, rw_reg);
  assign expire = (state_reg == ST_WAIT) && !match && (cnt_reg == LAST_WAIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (accept) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (match || expire) state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= REQ_A;
      last_reg      <= REQ_B;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rw_reg        <= 1'b0;
      cnt_reg       <= '0;
      a_rdata_reg   <= '0;
      b_rdata_reg   <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timed_out_reg <= expire;
      if (accept) begin
        owner_reg <= grant_a ? REQ_A : REQ_B;
        addr_reg  <= grant_a ? a_addr_i  : b_addr_i;
        wdata_reg <= grant_a ? a_wdata_i : b_wdata_i;
        rw_reg    <= grant_a ? a_rw_i    : b_rw_i;
      end
      if (state_reg == ST_ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
      // Response data lands in the owner's register as RESPOND begins, so it is
      // already visible during the completion pulse.
      if (match || expire) begin
        if (owner_reg == REQ_A) a_rdata_reg <= match ? rdata_i : '0;
        else                    b_rdata_reg <= match ? rdata_i : '0;
      end
      if (state_reg == ST_RESPOND) begin
        last_reg <= owner_reg;
      end
    end
  end

  assign valid_o   = (state_reg == ST_ISSUE);
  assign addr_o    = addr_reg;
  assign wdata_o   = wdata_reg;
  assign rw_o      = rw_reg;
  assign rdata_o   = '0;
  assign a_resp_o  = (state_reg == ST_RESPOND) && (owner_reg == REQ_A);
  assign b_resp_o  = (state_reg == ST_RESPOND) && (owner_reg == REQ_B);
  assign a_rdata_o = a_rdata_reg;
  assign b_rdata_o = b_rdata_reg;
  assign timeout_o = timed_out_reg;

  // Returning write data carries nothing the arbiter needs.
  assign unused_ok = ^wdata_i;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: WAIT cycles before an unanswered transaction is abandoned; legal range 1..65535.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 x_addr_i/x_wdata_i  in  16 each  requester x request address/data, x in {a,b}.
REQ-005 x_rw_i  in  1  requester x direction, 1 = write, 0 = read.
REQ-006 x_valid_i  in  1  requester x request pending; held with addr/wdata/rw until accepted.
REQ-007 x_ready_o  out  1  combinational grant; transfer when x_valid_i && x_ready_o.
REQ-008 x_rdata_o  out  16  requester x response data.
REQ-009 x_resp_o  out  1  one-cycle completion pulse to requester x.
REQ-010 addr_o/wdata_o/rdata_o  out  16 each  register bus into the core chain.
REQ-011 rw_o/valid_o  out  1 each  register bus into the core chain.
REQ-012 addr_i/wdata_i/rdata_i  in  16 each  register bus returning from the chain end.
REQ-013 rw_i/valid_i  in  1 each  register bus returning from the chain end.
REQ-014 timeout_o  out  1  one-cycle pulse when a transaction is abandoned.

Function
REQ-015 Four states: IDLE, ISSUE, WAIT, RESPOND; one transaction outstanding at most.
REQ-016 IDLE: winner = only valid requester; both valid -> requester not served last; x_ready_o high only for winner, only in IDLE.
REQ-017 Acceptance at edge T: latch addr/wdata/rw and owner, enter ISSUE.
REQ-018 ISSUE (cycle T+1): valid_o=1, addr_o/wdata_o/rw_o = latched values, rdata_o=0; clear timeout counter; enter WAIT.
REQ-019 valid_o 0 outside ISSUE; addr_o/wdata_o/rw_o hold latched values; rdata_o always 0.
REQ-020 WAIT: response = valid_i && addr_i==latched addr && rw_i==latched rw; capture rdata_i, enter RESPOND.
REQ-021 Reads and writes both complete on the returning beat; write response data is rdata_i as returned.
REQ-022 valid_i outside WAIT, or non-matching in WAIT, ignored with no state change.
REQ-023 WAIT counter increments per cycle; at TIMEOUT with no match: captured data 16'h0000, timeout_o=1 for one cycle, enter RESPOND.
REQ-024 Match on the cycle the counter hits TIMEOUT: match wins, no timeout_o.
REQ-025 RESPOND: owner x_resp_o=1 one cycle, owner x_rdata_o = captured data (held until next owner response); other port untouched; last-served = owner; enter IDLE.
REQ-026 Minimum accept-to-accept spacing 4 cycles; chain latency assumed >=1 cycle; return in ISSUE cycle not detected.
REQ-027 Requester dropping x_valid_i before acceptance: legal, no effect.
REQ-028 Undefined state encoding -> IDLE next cycle.

Reset
REQ-029 rst high: state IDLE, all outputs 0, x_rdata_o 0, counter 0, last-served = b (a wins first tie).
REQ-030 rst mid-transaction: transaction dropped, no x_resp_o or timeout_o; late return ignored in IDLE.

Structure
REQ-031 Bus width 16, state encodings, requester IDs in shared package bus_pkg.
REQ-032 One sub-module rr_grant2: 2-way round-robin grant from valids and last-served bit.

Verification
REQ-033 a read 0x0010, chain latency 3, returns rdata 0xBEEF -> valid_o in T+1, a_resp_o in T+5, a_rdata_o=0xBEEF, b outputs unchanged.
REQ-034 a,b valid same cycle after reset -> a granted first, b granted in IDLE after a_resp_o; b then a again -> a served before b's second request.
REQ-035 b write 0x0002 data 0x1234, return valid_i with addr 0x0002, rw=1 -> b_resp_o pulse, no timeout_o.
REQ-036 TIMEOUT=8, no return -> timeout_o and resp_o pulse same cycle, rdata 0x0000; later stray return ignored.
REQ-037 rst asserted in WAIT -> all outputs 0 immediately, next return ignored, next request serviced normally.
REQ-038 Return with addr mismatch in WAIT, then match -> only match completes; response data from the match.
